// File: rtl/display_share_scheduler_pkg.sv
// Shared types and constants for the display share scheduler.
// Requester indices, FSM states and the default dwell time.
package display_pkg;

  typedef enum logic {
    IDLE,
    SHOW
  } state_t;

  localparam logic [1:0] REQ_A      = 2'd0;
  localparam logic [1:0] REQ_B      = 2'd1;
  localparam logic [1:0] REQ_R      = 2'd2;
  localparam logic [1:0] OWNER_NONE = 2'd3;

  localparam int HOLD_CYCLES_DEFAULT = 27_000_000;

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    logic [2:0] oh;
    oh = 3'b000;
    unique case (idx)
      REQ_A:   oh = 3'b001;
      REQ_B:   oh = 3'b010;
      REQ_R:   oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/display_share_scheduler_if.sv
// Request/word bundle between the BCD sources and the scheduler.
// master = source side, slave = scheduler side.
interface display_share_scheduler_if;

  logic [2:0]  req_i;
  logic [15:0] bcd_a_i;
  logic [15:0] bcd_b_i;
  logic [15:0] bcd_r_i;
  logic [2:0]  ack_o;
  logic [15:0] bcd_o;
  logic [1:0]  owner_o;
  logic        busy_o;

  modport master (
    output req_i,
    output bcd_a_i,
    output bcd_b_i,
    output bcd_r_i,
    input  ack_o,
    input  bcd_o,
    input  owner_o,
    input  busy_o
  );

  modport slave (
    input  req_i,
    input  bcd_a_i,
    input  bcd_b_i,
    input  bcd_r_i,
    output ack_o,
    output bcd_o,
    output owner_o,
    output busy_o
  );

endinterface

// File: rtl/display_share_scheduler_rr_arbiter3.sv
// Three-way combinational round-robin arbiter.
// Search starts one past last_ptr; index 3 is never granted.
module rr_arbiter3
  import display_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last_ptr,
  output logic [2:0] gnt_onehot,
  output logic [1:0] gnt_idx,
  output logic       any
);

  logic [1:0] o0;
  logic [1:0] o1;
  logic [1:0] o2;

  // Search order derived from the last granted index.
  always_comb begin
    o0 = REQ_A;
    o1 = REQ_B;
    o2 = REQ_R;
    unique case (last_ptr)
      REQ_A: begin
        o0 = REQ_B;
        o1 = REQ_R;
        o2 = REQ_A;
      end
      REQ_B: begin
        o0 = REQ_R;
        o1 = REQ_A;
        o2 = REQ_B;
      end
      default: begin
        o0 = REQ_A;
        o1 = REQ_B;
        o2 = REQ_R;
      end
    endcase
  end

  // First pending requester in search order wins.
  always_comb begin
    gnt_idx = OWNER_NONE;
    if (req[o0])
      gnt_idx = o0;
    else if (req[o1])
      gnt_idx = o1;
    else if (req[o2])
      gnt_idx = o2;
  end

  assign any        = |req;
  assign gnt_onehot = onehot3(gnt_idx);

endmodule

// File: rtl/display_share_scheduler.sv
// Round-robin time-sharing of one 7-segment display among
// three BCD sources, with a minimum dwell per grant.
module display_share_scheduler
  import display_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_i,
  display_share_scheduler_if.slave  bus
);

  localparam int TW = $clog2(HOLD_CYCLES);
  localparam logic [TW-1:0] RELOAD = TW'(HOLD_CYCLES - 1);

  state_t        state;
  state_t        state_n;
  logic [TW-1:0] timer;
  logic [1:0]    last_ptr;
  logic [1:0]    owner;
  logic [15:0]   bcd;
  logic [2:0]    ack;

  logic [2:0]    gnt_onehot;
  logic [1:0]    gnt_idx;
  logic          any;
  logic          own_req;
  logic          do_grant;
  logic          do_refresh;
  logic [1:0]    sel_idx;
  logic [15:0]   sel_word;

  rr_arbiter3 u_arb (
    .req        (bus.req_i),
    .last_ptr   (last_ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (any)
  );

  assign own_req = |(bus.req_i & onehot3(owner));

  // Next state and grant/refresh decision.
  always_comb begin
    state_n    = state;
    do_grant   = 1'b0;
    do_refresh = 1'b0;
    unique case (state)
      IDLE: begin
        if (any) begin
          do_grant = 1'b1;
          state_n  = SHOW;
        end
      end
      SHOW: begin
        if (timer == '0) begin
          if (any)
            do_grant = 1'b1;
          else
            state_n = IDLE;
        end else if (own_req) begin
          do_refresh = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Refresh re-reads the current owner; a grant reads the winner.
  always_comb begin
    sel_idx  = do_grant ? gnt_idx : owner;
    sel_word = 16'h0000;
    unique case (1'b1)
      sel_idx == REQ_A: sel_word = bus.bcd_a_i;
      sel_idx == REQ_B: sel_word = bus.bcd_b_i;
      sel_idx == REQ_R: sel_word = bus.bcd_r_i;
      default:          sel_word = 16'h0000;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i)
      state <= IDLE;
    else
      state <= state_n;
  end

  // Output word, owner, ack pulse, pointer and dwell timer.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      bcd      <= 16'h0000;
      owner    <= OWNER_NONE;
      ack      <= 3'b000;
      last_ptr <= REQ_R;
      timer    <= '0;
    end else begin
      ack <= 3'b000;
      if (do_grant || do_refresh) begin
        bcd   <= sel_word;
        ack   <= onehot3(sel_idx);
        timer <= RELOAD;
      end else if (state == SHOW && timer != '0) begin
        timer <= timer - TW'(1);
      end
      if (do_grant) begin
        owner    <= gnt_idx;
        last_ptr <= gnt_idx;
      end
    end
  end

  assign bus.bcd_o   = bcd;
  assign bus.owner_o = owner;
  assign bus.ack_o   = ack;
  assign bus.busy_o  = (state == SHOW);

endmodule

// File: tb/tb_display_share_scheduler.sv
// Directed self-checking bench for display_share_scheduler.
// Dwell of 4 cycles; outputs sampled 1 ns after each rising edge.
module tb_display_share_scheduler;

  logic clk;
  logic rst_i;
  int   n_cmp;
  int   n_err;

  display_share_scheduler_if bus ();

  display_share_scheduler #(
    .HOLD_CYCLES (4)
  ) dut (
    .clk   (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_i       = 1'b1;
    bus.req_i   = 3'b000;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      n_cmp++;
      if ({bus.bcd_o, bus.owner_o, bus.ack_o, bus.busy_o} !==
          {16'h0000, 2'd3, 3'b000, 1'b0}) begin
        n_err++;
        $display("FAIL reset_idle[%0d]: got bcd=%h own=%0d ack=%b busy=%b want 0000/3/000/0",
                 i, bus.bcd_o, bus.owner_o, bus.ack_o, bus.busy_o);
      end
      tick();
    end
  endtask

  task automatic test_single;
    do_reset();
    bus.bcd_a_i = 16'h1234;
    bus.req_i   = 3'b001;
    tick();
    n_cmp++;
    if ({bus.ack_o, bus.bcd_o, bus.owner_o, bus.busy_o} !==
        {3'b001, 16'h1234, 2'd0, 1'b1}) begin
      n_err++;
      $display("FAIL single_grant: got ack=%b bcd=%h own=%0d busy=%b want 001/1234/0/1",
               bus.ack_o, bus.bcd_o, bus.owner_o, bus.busy_o);
    end
    bus.req_i = 3'b000;
    for (int i = 1; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({bus.busy_o, bus.ack_o} !== {1'b1, 3'b000}) begin
        n_err++;
        $display("FAIL single_dwell[%0d]: got busy=%b ack=%b want 1/000",
                 i, bus.busy_o, bus.ack_o);
      end
    end
    tick();
    n_cmp++;
    if ({bus.busy_o, bus.bcd_o, bus.owner_o} !== {1'b0, 16'h1234, 2'd0}) begin
      n_err++;
      $display("FAIL single_idle: got busy=%b bcd=%h own=%0d want 0/1234/0",
               bus.busy_o, bus.bcd_o, bus.owner_o);
    end
  endtask

  task automatic test_all_three;
    logic [2:0]  exp_ack [3];
    logic [15:0] exp_bcd [3];
    logic [2:0]  pend;
    exp_ack = '{3'b001, 3'b010, 3'b100};
    exp_bcd = '{16'h0011, 16'h0022, 16'h0099};
    do_reset();
    bus.bcd_a_i = 16'h0011;
    bus.bcd_b_i = 16'h0022;
    bus.bcd_r_i = 16'h0099;
    pend        = 3'b111;
    bus.req_i   = pend;
    for (int g = 0; g < 3; g++) begin
      if (g != 0) begin
        for (int i = 1; i < 4; i++) begin
          tick();
          n_cmp++;
          if (bus.ack_o !== 3'b000) begin
            n_err++;
            $display("FAIL all3_gap[%0d.%0d]: got ack=%b want 000",
                     g, i, bus.ack_o);
          end
        end
      end
      tick();
      n_cmp++;
      if ({bus.ack_o, bus.bcd_o} !== {exp_ack[g], exp_bcd[g]}) begin
        n_err++;
        $display("FAIL all3_grant[%0d]: got ack=%b bcd=%h want %b/%h",
                 g, bus.ack_o, bus.bcd_o, exp_ack[g], exp_bcd[g]);
      end
      pend      = pend & ~exp_ack[g];
      bus.req_i = pend;
    end
  endtask

  task automatic test_refresh;
    do_reset();
    bus.bcd_a_i = 16'h0777;
    bus.bcd_b_i = 16'h0333;
    bus.req_i   = 3'b010;
    tick();
    n_cmp++;
    if ({bus.ack_o, bus.bcd_o, bus.owner_o} !== {3'b010, 16'h0333, 2'd1}) begin
      n_err++;
      $display("FAIL refresh_setup: got ack=%b bcd=%h own=%0d want 010/0333/1",
               bus.ack_o, bus.bcd_o, bus.owner_o);
    end
    bus.req_i = 3'b001;
    tick();
    bus.req_i   = 3'b011;
    bus.bcd_b_i = 16'h0456;
    tick();
    n_cmp++;
    if ({bus.ack_o, bus.bcd_o, bus.owner_o} !== {3'b010, 16'h0456, 2'd1}) begin
      n_err++;
      $display("FAIL refresh_update: got ack=%b bcd=%h own=%0d want 010/0456/1",
               bus.ack_o, bus.bcd_o, bus.owner_o);
    end
    bus.req_i = 3'b001;
    for (int i = 1; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({bus.ack_o, bus.bcd_o} !== {3'b000, 16'h0456}) begin
        n_err++;
        $display("FAIL refresh_hold[%0d]: got ack=%b bcd=%h want 000/0456",
                 i, bus.ack_o, bus.bcd_o);
      end
    end
    tick();
    n_cmp++;
    if ({bus.ack_o, bus.bcd_o, bus.owner_o} !== {3'b001, 16'h0777, 2'd0}) begin
      n_err++;
      $display("FAIL refresh_next: got ack=%b bcd=%h own=%0d want 001/0777/0",
               bus.ack_o, bus.bcd_o, bus.owner_o);
    end
    bus.req_i = 3'b000;
  endtask

  task automatic test_fairness;
    logic [2:0] exp;
    do_reset();
    bus.bcd_a_i = 16'h0001;
    bus.bcd_r_i = 16'h0002;
    bus.req_i   = 3'b101;
    tick();
    exp = 3'b001;
    n_cmp++;
    if (bus.ack_o !== exp) begin
      n_err++;
      $display("FAIL fair_first: got ack=%b want %b", bus.ack_o, exp);
    end
    for (int g = 1; g < 6; g++) begin
      bus.req_i = 3'b101 & ~exp;
      for (int i = 1; i < 4; i++) begin
        tick();
        n_cmp++;
        if (bus.ack_o !== 3'b000) begin
          n_err++;
          $display("FAIL fair_gap[%0d.%0d]: got ack=%b want 000",
                   g, i, bus.ack_o);
        end
      end
      bus.req_i = 3'b101;
      exp       = (exp == 3'b001) ? 3'b100 : 3'b001;
      tick();
      n_cmp++;
      if (bus.ack_o !== exp) begin
        n_err++;
        $display("FAIL fair_grant[%0d]: got ack=%b want %b",
                 g, bus.ack_o, exp);
      end
    end
    bus.req_i = 3'b000;
  endtask

  task automatic test_reset_mid;
    do_reset();
    bus.bcd_a_i = 16'h0321;
    bus.bcd_r_i = 16'h0789;
    bus.req_i   = 3'b100;
    tick();
    n_cmp++;
    if ({bus.ack_o, bus.bcd_o, bus.owner_o} !== {3'b100, 16'h0789, 2'd2}) begin
      n_err++;
      $display("FAIL midrst_grant: got ack=%b bcd=%h own=%0d want 100/0789/2",
               bus.ack_o, bus.bcd_o, bus.owner_o);
    end
    bus.req_i = 3'b000;
    tick();
    tick();
    bus.req_i = 3'b001;
    rst_i     = 1'b1;
    #1;
    n_cmp++;
    if ({bus.bcd_o, bus.owner_o, bus.ack_o, bus.busy_o} !==
        {16'h0000, 2'd3, 3'b000, 1'b0}) begin
      n_err++;
      $display("FAIL midrst_async: got bcd=%h own=%0d ack=%b busy=%b want 0000/3/000/0",
               bus.bcd_o, bus.owner_o, bus.ack_o, bus.busy_o);
    end
    tick();
    rst_i = 1'b0;
    tick();
    n_cmp++;
    if ({bus.ack_o, bus.bcd_o, bus.owner_o, bus.busy_o} !==
        {3'b001, 16'h0321, 2'd0, 1'b1}) begin
      n_err++;
      $display("FAIL midrst_regrant: got ack=%b bcd=%h own=%0d busy=%b want 001/0321/0/1",
               bus.ack_o, bus.bcd_o, bus.owner_o, bus.busy_o);
    end
    bus.req_i = 3'b000;
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst_i       = 1'b1;
    bus.req_i   = 3'b000;
    bus.bcd_a_i = 16'h0000;
    bus.bcd_b_i = 16'h0000;
    bus.bcd_r_i = 16'h0000;
    test_reset();
    test_single();
    test_all_three();
    test_refresh();
    test_fairness();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
